// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed UART byte stream into RAM, then serves fetches.
// Optional trailing XOR checksum byte is enabled with the IMEM_LOAD_CHECKSUM_EN macro.
module imem_loader #(
  parameter int INST_SIZE = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           mode,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic                 done,
  output logic                 err,
  output logic [INST_SIZE:0]   word_count
);

  localparam int                 DEPTH     = 2**INST_SIZE;
  localparam logic [31:0]        DEPTH32   = 32'(DEPTH);
  localparam logic [INST_SIZE:0] DEPTH_W   = (INST_SIZE+1)'(DEPTH);
  localparam logic [INST_SIZE:0] ONE_W     = {{INST_SIZE{1'b0}}, 1'b1};
  localparam logic [2:0]         MODE_LOAD = 3'd1;

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1, ST_DONE = 2'd2, ST_CSUM = 2'd3} state_t;
  localparam state_t LOAD_END = ST_CSUM;
`else
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1, ST_DONE = 2'd2} state_t;
  localparam state_t LOAD_END = ST_DONE;
`endif

  state_t               state_reg, state_next;
  logic [1:0]           byte_cnt_reg, byte_cnt_next;
  logic [23:0]          asm_reg, asm_next;
  logic [INST_SIZE:0]   len_reg, len_next;
  logic [INST_SIZE:0]   word_count_reg, word_count_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic                 wr_pend_reg, wr_pend_next;
  logic [31:0]          wr_data_reg, wr_data_next;
  logic [31:0]          inst_reg;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]           csum_reg, csum_next;
`endif

  logic [31:0] ram [DEPTH];

  logic        accept;
  logic        byte_last;
  logic [31:0] full_word;
  logic        unused_pc;

  assign accept    = rx_valid && (mode == MODE_LOAD) && (state_reg != ST_DONE);
  assign byte_last = (byte_cnt_reg == 2'd3);
  assign full_word = {asm_reg, rx_data};
  assign unused_pc = ^{pc[31:INST_SIZE+2], pc[1:0]};

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    asm_next        = asm_reg;
    len_next        = len_reg;
    err_next        = err_reg;
    wr_pend_next    = 1'b0;
    wr_data_next    = wr_data_reg;
    word_count_next = wr_pend_reg ? (word_count_reg + ONE_W) : word_count_reg;
    done_next       = (state_reg == ST_DONE);
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    if (accept) begin
      case (state_reg)
        ST_HDR: begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
          asm_next      = {asm_reg[15:0], rx_data};
          if (byte_last) begin
            if (full_word > DEPTH32) begin
              err_next = 1'b1;
              len_next = DEPTH_W;
            end else begin
              len_next = full_word[INST_SIZE:0];
            end
            state_next = (full_word == 32'd0) ? LOAD_END : ST_DATA;
          end
        end
        ST_DATA: begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
          asm_next      = {asm_reg[15:0], rx_data};
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_next     = csum_reg ^ rx_data;
`endif
          if (byte_last) begin
            wr_pend_next = 1'b1;
            wr_data_next = full_word;
            // Decide the exit now so a byte following the last data byte is never mistaken for data.
            if ((word_count_reg + ONE_W) == len_reg) state_next = LOAD_END;
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        ST_CSUM: begin
          state_next = ST_DONE;
          if (rx_data != csum_reg) err_next = 1'b1;
        end
`endif
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_HDR;
      byte_cnt_reg   <= 2'd0;
      asm_reg        <= 24'd0;
      len_reg        <= '0;
      word_count_reg <= '0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
      wr_pend_reg    <= 1'b0;
      wr_data_reg    <= 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_reg       <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      asm_reg        <= asm_next;
      len_reg        <= len_next;
      word_count_reg <= word_count_next;
      err_reg        <= err_next;
      done_reg       <= done_next;
      wr_pend_reg    <= wr_pend_next;
      wr_data_reg    <= wr_data_next;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_pend_reg) ram[word_count_reg[INST_SIZE-1:0]] <= wr_data_reg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) inst_reg <= 32'd0;
    else       inst_reg <= ram[pc[INST_SIZE+1:2]];
  end

  assign inst       = inst_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (INST_SIZE = 4): load, fetch, empty image, clamp, stall and reset cases.
module tb_imem_loader;

  localparam int IS = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    mode;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          done;
  logic          err;
  logic [IS:0]   word_count;

  int tests = 0;
  int fails = 0;

  imem_loader #(.INST_SIZE(IS)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .pc(pc), .inst(inst), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    rx_valid = 1'b0;
    mode     = 3'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(b);
`else
    if (b === 8'hxx) $display("[TB] unreachable");
`endif
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic read_inst(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    pc = addr;
    @(negedge clk);
    check_eq(tag, inst, exp);
  endtask

  initial begin
    rstn = 1'b0; mode = 3'd0; rx_data = 8'd0; rx_valid = 1'b0; pc = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_wc", 32'(word_count), 32'd0);
    rstn = 1'b1;

    // Two-word image
    mode = 3'd1;
    send_word(32'h0000_0002);
    send_word(32'h1234_5678);
    send_word(32'hABCD_EF01);
    send_csum(8'h80);
    wait_done("t1_done");
    check_eq("t1_wc", 32'(word_count), 32'd2);
    check_eq("t1_err", 32'(err), 32'd0);
    send_byte(8'h55);
    @(negedge clk);
    check_eq("t1_trail_wc", 32'(word_count), 32'd2);
    check_eq("t1_trail_err", 32'(err), 32'd0);

    // Fetch, latency and address wrap
    mode = 3'd2;
    read_inst("t2_pc4", 32'h4, 32'hABCD_EF01);
    @(negedge clk);
    pc = 32'h0;
    #1 check_eq("t2_latency_hold", inst, 32'hABCD_EF01);
    @(negedge clk);
    check_eq("t2_pc0", inst, 32'h1234_5678);
    read_inst("t2_wrap", 32'h0000_0047, 32'hABCD_EF01);

    // Empty image
    do_reset();
    mode = 3'd1;
    send_word(32'h0);
    send_csum(8'h00);
    wait_done("t3_done");
    check_eq("t3_wc", 32'(word_count), 32'd0);
    send_word(32'hAABB_CCDD);
    @(negedge clk);
    check_eq("t3_wc_after", 32'(word_count), 32'd0);

    // Oversized header clamps to depth 16
    do_reset();
    mode = 3'd1;
    send_word(32'h0000_0020);
    check_eq("t4_err", 32'(err), 32'd1);
    for (int i = 0; i < 15; i++) send_word(32'h1000_0000 + 32'(i));
    @(negedge clk);
    check_eq("t4_wc15", 32'(word_count), 32'd15);
    check_eq("t4_not_done", 32'(done), 32'd0);
    send_word(32'h1000_000F);
    send_csum(8'h00);
    wait_done("t4_done");
    check_eq("t4_wc16", 32'(word_count), 32'd16);
    check_eq("t4_err_sticky", 32'(err), 32'd1);
    mode = 3'd2;
    read_inst("t4_last", 32'h3C, 32'h1000_000F);

    // Mode leaves LOAD mid-word; stray bytes are dropped
    do_reset();
    mode = 3'd1;
    send_word(32'h0000_0002);
    send_byte(8'hDE); send_byte(8'hAD);
    mode = 3'd0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    mode = 3'd1;
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'hCA); send_byte(8'hFE);
    mode = 3'd3;
    send_byte(8'h99); send_byte(8'h98);
    mode = 3'd1;
    send_byte(8'hBA); send_byte(8'hBE);
    send_csum(8'h12);
    wait_done("t5_done");
    check_eq("t5_wc", 32'(word_count), 32'd2);
    check_eq("t5_err", 32'(err), 32'd0);
    mode = 3'd2;
    read_inst("t5_w0", 32'h0, 32'hDEAD_BEEF);
    read_inst("t5_w1", 32'h4, 32'hCAFE_BABE);

    // Reset mid-word restarts at header byte 0
    do_reset();
    mode = 3'd1;
    send_word(32'h0000_0002);
    send_word(32'h5555_5555);
    send_byte(8'h01); send_byte(8'h02);
    check_eq("t6_wc_pre", 32'(word_count), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_done", 32'(done), 32'd0);
    check_eq("t6_rst_wc", 32'(word_count), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
`ifdef IMEM_LOAD_CHECKSUM_EN
    repeat (2) @(negedge clk);
    check_eq("t6_wait_csum", 32'(done), 32'd0);
`endif
    send_csum(8'h04);
    wait_done("t6_done");
    check_eq("t6_wc", 32'(word_count), 32'd1);
    check_eq("t6_err", 32'(err), 32'd0);
    mode = 3'd2;
    read_inst("t6_w0", 32'h0, 32'h0102_0304);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Bad checksum
    do_reset();
    mode = 3'd1;
    send_word(32'h0000_0001);
    send_word(32'h0102_0304);
    send_byte(8'h05);
    wait_done("t7_done");
    check_eq("t7_err", 32'(err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
